// File: rtl/bist_vector_mem.sv
// bist_vector_mem
// Test-vector store and read responder for the on-chip BIST engine.
// The JTAG data-register path loads vectors serially into load_sr
// ({waddr, wdata}); update_en commits them to the array, either at the
// address held in load_sr (burst = 0) or at an auto-incrementing pointer
// (burst = 1). The BIST engine reads with read_mem/addr and gets mem_data
// one clock later. Writes are refused while bist_active is high.
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   read_mem, addr        read request and address from the BIST engine
//   mem_data              registered read data
//   shift_en, tdi, tdo    serial load path (tdo = load_sr[0])
//   update_en, burst      commit strobe and commit mode
//   bist_active           write lockout
//   clr_err, write_err    sticky rejected-write flag and its clear
//   wr_count              accepted writes, saturating at 9'h1FF
module bist_vector_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_mem,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              shift_en,
  input  logic              tdi,
  output logic              tdo,
  input  logic              update_en,
  input  logic              burst,
  input  logic              bist_active,
  input  logic              clr_err,
  output logic              write_err,
  output logic [8:0]        wr_count
);

  localparam int SR_W  = ADDR_W + DATA_W;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [SR_W-1:0]   load_sr;
  logic [ADDR_W-1:0] ptr;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Commit decode uses the pre-shift load_sr, so a shift in the same cycle
  // does not disturb the word being written.
  always_comb begin
    wr_en   = update_en & ~bist_active;
    wr_addr = burst ? ptr : load_sr[SR_W-1:DATA_W];
    wr_data = load_sr[DATA_W-1:0];
  end

  assign tdo = load_sr[0];

  // Array is deliberately not reset so vectors survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_sr   <= '0;
      ptr       <= '0;
      wr_count  <= '0;
      write_err <= 1'b0;
      mem_data  <= '0;
    end else begin
      if (shift_en) load_sr <= {tdi, load_sr[SR_W-1:1]};

      if (wr_en) begin
        ptr <= wr_addr + ADDR_W'(1);
        if (wr_count != 9'h1FF) wr_count <= wr_count + 9'd1;
      end

      // A rejected commit beats a simultaneous clear.
      if (update_en && bist_active) write_err <= 1'b1;
      else if (clr_err)             write_err <= 1'b0;

      // Write-first bypass: the array write lands after this edge.
      if (read_mem) begin
        if (wr_en && (wr_addr == addr)) mem_data <= wr_data;
        else                            mem_data <= mem[addr];
      end
    end
  end

endmodule

// File: tb/tb_bist_vector_mem.sv
module tb_bist_vector_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       read_mem;
  logic [7:0] addr;
  logic [7:0] mem_data;
  logic       shift_en;
  logic       tdi;
  logic       tdo;
  logic       update_en;
  logic       burst;
  logic       bist_active;
  logic       clr_err;
  logic       write_err;
  logic [8:0] wr_count;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] sb [$];   // {addr, expected data}

  always #5 clk = ~clk;

  bist_vector_mem #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .read_mem(read_mem), .addr(addr),
    .mem_data(mem_data), .shift_en(shift_en), .tdi(tdi), .tdo(tdo),
    .update_en(update_en), .burst(burst), .bist_active(bist_active),
    .clr_err(clr_err), .write_err(write_err), .wr_count(wr_count)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic shift_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      shift_en = 1'b1;
      tdi      = w[i];
      @(negedge clk);
    end
    shift_en = 1'b0;
    tdi      = 1'b0;
  endtask

  task automatic update(input logic b);
    update_en = 1'b1;
    burst     = b;
    @(negedge clk);
    update_en = 1'b0;
    burst     = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp);
    read_mem = 1'b1;
    addr     = a;
    sb.push_back({a, exp});
    @(negedge clk);
    read_mem = 1'b0;
  endtask

  // Monitor: every read accepted at a rising edge is checked 1 time unit later.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1 && read_mem === 1'b1) begin
        #1;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL read_unexpected: got %h expected none", mem_data);
        end else begin
          e = sb.pop_front();
          chk($sformatf("read[%h]", e[15:8]), {8'h00, mem_data}, {8'h00, e[7:0]});
        end
      end
    end
  end

  initial begin
    #100000;
    vectors++;
    miscompares++;
    $display("FAIL timeout: got running expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    rst_n = 1'b0; read_mem = 1'b0; addr = '0; shift_en = 1'b0; tdi = 1'b0;
    update_en = 1'b0; burst = 1'b0; bist_active = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_data", {8'h00, mem_data}, 16'h0000);
    chk("rst_tdo", {15'h0, tdo}, 16'h0000);
    chk("rst_write_err", {15'h0, write_err}, 16'h0000);
    chk("rst_wr_count", {7'h0, wr_count}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Addressed write
    shift_bits(16'h05A7, 16);
    chk("tdo_after_load", {15'h0, tdo}, 16'h0001);
    update(1'b0);
    chk("wr_count_1", {7'h0, wr_count}, 16'h0001);
    rd(8'h05, 8'hA7);

    // Addressed then burst with pointer wrap
    shift_bits(16'hFE11, 16); update(1'b0);
    shift_bits(16'h7722, 16); update(1'b1);
    shift_bits(16'h4433, 16); update(1'b1);
    chk("wr_count_4", {7'h0, wr_count}, 16'h0004);
    rd(8'hFE, 8'h11);
    rd(8'hFF, 8'h22);
    rd(8'h00, 8'h33);
    rd(8'h05, 8'hA7);

    // Lockout and sticky error
    bist_active = 1'b1;
    shift_bits(16'h0599, 16); update(1'b0);
    chk("lock_write_err", {15'h0, write_err}, 16'h0001);
    chk("lock_wr_count", {7'h0, wr_count}, 16'h0004);
    rd(8'h05, 8'hA7);
    clr_err = 1'b1; update(1'b1); clr_err = 1'b0;
    chk("clr_vs_set", {15'h0, write_err}, 16'h0001);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("clr_alone", {15'h0, write_err}, 16'h0000);
    bist_active = 1'b0;
    // Rejected commits must not have moved ptr off 8'h01
    shift_bits(16'h00BE, 16); update(1'b1);
    chk("wr_count_5", {7'h0, wr_count}, 16'h0005);
    rd(8'h01, 8'hBE);

    // Same-cycle write and read of one address
    shift_bits(16'h105C, 16);
    update_en = 1'b1; burst = 1'b0; read_mem = 1'b1; addr = 8'h10;
    sb.push_back({8'h10, 8'h5C});
    @(negedge clk);
    update_en = 1'b0; read_mem = 1'b0;
    chk("wr_count_6", {7'h0, wr_count}, 16'h0006);

    // Same-cycle shift and commit: pre-shift word 16'h20C3 is written
    shift_bits(16'h20C3, 16);
    shift_en = 1'b1; tdi = 1'b1; update_en = 1'b1; burst = 1'b0;
    @(negedge clk);
    shift_en = 1'b0; tdi = 1'b0; update_en = 1'b0;
    chk("wr_count_7", {7'h0, wr_count}, 16'h0007);
    chk("tdo_post_shift", {15'h0, tdo}, 16'h0001);
    rd(8'h20, 8'hC3);

    // Reset mid-shift and mid-read
    shift_bits(16'h30FF, 16);
    shift_bits(16'hAAAA, 7);
    chk("tdo_pre_reset", {15'h0, tdo}, 16'h0001);
    chk("mem_data_pre_reset", {8'h00, mem_data}, 16'h00C3);
    shift_en = 1'b1; tdi = 1'b1; read_mem = 1'b1; addr = 8'h20;
    #2 rst_n = 1'b0;
    #1;
    chk("async_mem_data", {8'h00, mem_data}, 16'h0000);
    chk("async_tdo", {15'h0, tdo}, 16'h0000);
    chk("async_wr_count", {7'h0, wr_count}, 16'h0000);
    @(negedge clk);
    shift_en = 1'b0; tdi = 1'b0; read_mem = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    shift_bits(16'h4277, 16); update(1'b0);
    chk("wr_count_after_rst", {7'h0, wr_count}, 16'h0001);
    rd(8'h42, 8'h77);
    rd(8'h05, 8'hA7);
    rd(8'hFE, 8'h11);
    rd(8'hFF, 8'h22);
    rd(8'h00, 8'h33);
    rd(8'h01, 8'hBE);
    rd(8'h10, 8'h5C);
    rd(8'h20, 8'hC3);

    // Saturation: 600 back-to-back burst commits of data 8'h77
    update_en = 1'b1; burst = 1'b1;
    repeat (600) @(negedge clk);
    update_en = 1'b0; burst = 1'b0;
    chk("wr_count_sat", {7'h0, wr_count}, 16'h01FF);
    rd(8'h05, 8'h77);

    repeat (3) @(negedge clk);
    chk("sb_drain", 16'(sb.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
